// File: rtl/rf_arbiter_if.sv
// Client and register-file signal bundle for rf_arbiter.
// slave = arbiter side, master = clients plus the register file read path.
interface rf_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          reqA, wrA, ackA, rvalidA;
  logic [AW-1:0] addrA;
  logic [DW-1:0] wdataA;
  logic          reqB, wrB, ackB, rvalidB;
  logic [AW-1:0] addrB;
  logic [DW-1:0] wdataB;
  logic [DW-1:0] rdata;
  logic          WEN;
  logic [AW-1:0] RW, RX;
  logic [DW-1:0] busW, busX;

  modport slave (
    input  reqA, wrA, addrA, wdataA,
    input  reqB, wrB, addrB, wdataB,
    input  busX,
    output ackA, ackB, rdata, rvalidA, rvalidB,
    output WEN, RW, busW, RX
  );

  modport master (
    output reqA, wrA, addrA, wdataA,
    output reqB, wrB, addrB, wdataB,
    output busX,
    input  ackA, ackB, rdata, rvalidA, rvalidB,
    input  WEN, RW, busW, RX
  );
endinterface

// File: rtl/rf_arbiter.sv
// Two-client req/ack arbiter sequencing single ops onto a register file write port and X read port.
// Define RF_ARB_FIXED_PRIO_EN for fixed priority (A wins ties); default is round-robin.
module rf_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input logic         Clk,
  input logic         Rst,
  rf_arbiter_if.slave bus
);
  localparam int NCLI = 2;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  typedef struct packed {
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cli_req_t;

  cli_req_t [NCLI-1:0] cli;
  state_e              state_q, state_d;
  logic                win_q, win_d;
  logic                wr_q, wr_d;
  logic [AW-1:0]       rw_q, rw_d, rx_q, rx_d;
  logic [DW-1:0]       busw_q, busw_d, rdata_q, rdata_d;
  logic [NCLI-1:0]     rvalid_q, rvalid_d, ack;
  logic                any_req, pick;

  assign cli[0] = cli_req_t'{req: bus.reqA, wr: bus.wrA, addr: bus.addrA, wdata: bus.wdataA};
  assign cli[1] = cli_req_t'{req: bus.reqB, wr: bus.wrB, addr: bus.addrB, wdata: bus.wdataB};
  assign any_req = cli[0].req | cli[1].req;

  // pick: 0 = A, 1 = B; only meaningful while any_req is high
`ifdef RF_ARB_FIXED_PRIO_EN
  assign pick = ~cli[0].req;
`else
  logic last_q, last_d;

  assign pick = (cli[0].req & cli[1].req) ? ~last_q : cli[1].req;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && any_req) last_d = pick;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    wr_d     = wr_q;
    rw_d     = rw_q;
    busw_d   = busw_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          win_d   = pick;
          wr_d    = cli[pick].wr;
          if (cli[pick].wr) begin
            rw_d   = cli[pick].addr;
            busw_d = cli[pick].wdata;
          end else begin
            rx_d   = cli[pick].addr;
          end
        end
      end
      ISSUE: begin
        state_d = IDLE;
        // busX is combinational from RX, so the read completes as ISSUE ends
        if (!wr_q) begin
          rdata_d         = bus.busX;
          rvalid_d[win_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      wr_q     <= 1'b0;
      rw_q     <= '0;
      busw_q   <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      rw_q     <= rw_d;
      busw_q   <= busw_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  for (genvar i = 0; i < NCLI; i++) begin : g_ack
    assign ack[i] = (state_q == ISSUE) && (win_q == 1'(i));
  end

  // WEN decodes from state, so an async reset during ISSUE kills the write at once
  assign bus.WEN     = (state_q == ISSUE) && wr_q;
  assign bus.RW      = rw_q;
  assign bus.busW    = busw_q;
  assign bus.RX      = rx_q;
  assign bus.rdata   = rdata_q;
  assign bus.ackA    = ack[0];
  assign bus.ackB    = ack[1];
  assign bus.rvalidA = rvalid_q[0];
  assign bus.rvalidB = rvalid_q[1];

  a_single_ack: assert property (@(posedge Clk) disable iff (Rst) !(ack[0] && ack[1]));
  a_ack_rvalid: assert property (@(posedge Clk) disable iff (Rst) !((|ack) && (|rvalid_q)));
endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter with a behavioural 8x8 register file on the write/X-read ports.
module tb_rf_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rf_arbiter_if #(.DW(8), .AW(3)) bus ();

  rf_arbiter #(.DW(8), .AW(3)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  // register file: reg 0 reads zero and ignores writes
  logic [7:0] rf [0:7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  always @(posedge clk) if (bus.WEN && bus.RW != 3'd0) rf[bus.RW] <= bus.busW;
  assign bus.busX = (bus.RX == 3'd0) ? 8'h00 : rf[bus.RX];

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic a_write(input logic [2:0] a, input logic [7:0] d);
    bus.reqA = 1'b1; bus.wrA = 1'b1; bus.addrA = a; bus.wdataA = d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.reqA = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.WEN !== 1'b0) begin n_err++; $display("FAIL rst_wen: got %b want 0", bus.WEN); end
    n_cmp++; if ({bus.ackA, bus.ackB, bus.rvalidA, bus.rvalidB} !== 4'b0) begin
      n_err++; $display("FAIL rst_strobes: got %b want 0000", {bus.ackA, bus.ackB, bus.rvalidA, bus.rvalidB}); end
    n_cmp++; if ({bus.RW, bus.RX, bus.busW, bus.rdata} !== 22'h0) begin
      n_err++; $display("FAIL rst_regs: got RW=%0d RX=%0d busW=%h rdata=%h want 0", bus.RW, bus.RX, bus.busW, bus.rdata); end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++; if ({bus.WEN, bus.ackA, bus.ackB, bus.rvalidA, bus.rvalidB} !== 5'b0) begin
        n_err++; $display("FAIL idle_quiet: cycle %0d got %b want 00000", c,
                          {bus.WEN, bus.ackA, bus.ackB, bus.rvalidA, bus.rvalidB}); end
    end
  endtask

  task automatic test_write_read();
    bus.reqA = 1'b1; bus.wrA = 1'b1; bus.addrA = 3'd3; bus.wdataA = 8'hA5;
    @(posedge clk); #1;
    n_cmp++; if ({bus.ackA, bus.ackB, bus.WEN} !== 3'b101) begin
      n_err++; $display("FAIL wr_issue: got ackA,ackB,WEN=%b want 101", {bus.ackA, bus.ackB, bus.WEN}); end
    n_cmp++; if (bus.RW !== 3'd3 || bus.busW !== 8'hA5) begin
      n_err++; $display("FAIL wr_bus: got RW=%0d busW=%h want 3 A5", bus.RW, bus.busW); end
    @(posedge clk); #1;
    n_cmp++; if ({bus.ackA, bus.WEN, bus.rvalidA} !== 3'b000) begin
      n_err++; $display("FAIL wr_done: got ackA,WEN,rvalidA=%b want 000", {bus.ackA, bus.WEN, bus.rvalidA}); end
    n_cmp++; if (rf[3] !== 8'hA5) begin n_err++; $display("FAIL wr_rf3: got %h want a5", rf[3]); end
    bus.wrA = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({bus.ackA, bus.WEN, bus.RX} !== {1'b1, 1'b0, 3'd3}) begin
      n_err++; $display("FAIL rd_issue: got ackA=%b WEN=%b RX=%0d want 1 0 3", bus.ackA, bus.WEN, bus.RX); end
    @(posedge clk); #1;
    bus.reqA = 1'b0;
    n_cmp++; if ({bus.rvalidA, bus.rvalidB, bus.ackA} !== 3'b100) begin
      n_err++; $display("FAIL rd_valid: got rvalidA,rvalidB,ackA=%b want 100", {bus.rvalidA, bus.rvalidB, bus.ackA}); end
    n_cmp++; if (bus.rdata !== 8'hA5) begin n_err++; $display("FAIL rd_data: got %h want a5", bus.rdata); end
    @(posedge clk); #1;
    n_cmp++; if (bus.rvalidA !== 1'b0 || bus.rdata !== 8'hA5) begin
      n_err++; $display("FAIL rd_hold: got rvalidA=%b rdata=%h want 0 a5", bus.rvalidA, bus.rdata); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_b;
`ifdef RF_ARB_FIXED_PRIO_EN
    exp_b = 4'b0000;
`else
    exp_b = 4'b1010;
`endif
    apply_reset();
    bus.reqA = 1'b1; bus.wrA = 1'b1; bus.addrA = 3'd1; bus.wdataA = 8'h11;
    bus.reqB = 1'b1; bus.wrB = 1'b1; bus.addrB = 3'd2; bus.wdataB = 8'h22;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_cmp++; if ({bus.ackA, bus.ackB} !== {~exp_b[k], exp_b[k]}) begin
        n_err++; $display("FAIL rr_grant%0d: got ackA,ackB=%b want %b", k, {bus.ackA, bus.ackB}, {~exp_b[k], exp_b[k]}); end
      @(posedge clk); #1;
      n_cmp++; if ({bus.ackA, bus.ackB} !== 2'b00) begin
        n_err++; $display("FAIL rr_gap%0d: got ackA,ackB=%b want 00", k, {bus.ackA, bus.ackB}); end
    end
    bus.reqA = 1'b0; bus.reqB = 1'b0;
    n_cmp++; if (rf[1] !== 8'h11) begin n_err++; $display("FAIL rr_rf1: got %h want 11", rf[1]); end
`ifdef RF_ARB_FIXED_PRIO_EN
    n_cmp++; if (rf[2] !== 8'h00) begin n_err++; $display("FAIL rr_rf2: got %h want 00", rf[2]); end
`else
    n_cmp++; if (rf[2] !== 8'h22) begin n_err++; $display("FAIL rr_rf2: got %h want 22", rf[2]); end
`endif
  endtask

  task automatic test_reg0();
    bus.reqA = 1'b1; bus.wrA = 1'b1; bus.addrA = 3'd0; bus.wdataA = 8'hFF;
    @(posedge clk); #1;
    n_cmp++; if ({bus.WEN, bus.RW, bus.busW} !== {1'b1, 3'd0, 8'hFF}) begin
      n_err++; $display("FAIL r0_write: got WEN=%b RW=%0d busW=%h want 1 0 ff", bus.WEN, bus.RW, bus.busW); end
    @(posedge clk); #1;
    bus.wrA = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.reqA = 1'b0;
    n_cmp++; if (bus.rvalidA !== 1'b1 || bus.rdata !== 8'h00) begin
      n_err++; $display("FAIL r0_read: got rvalidA=%b rdata=%h want 1 00", bus.rvalidA, bus.rdata); end
  endtask

  task automatic test_mixed();
    int         first;
    logic       drop_a, drop_b, got_a, got_rd;
    logic [7:0] rd, exp_rd;
    a_write(3'd5, 8'h5A);
`ifdef RF_ARB_FIXED_PRIO_EN
    exp_rd = 8'h3C;
`else
    exp_rd = 8'h5A;
`endif
    first = 0; drop_a = 0; drop_b = 0; got_a = 0; got_rd = 0; rd = 8'h00;
    bus.reqA = 1'b1; bus.wrA = 1'b1; bus.addrA = 3'd5; bus.wdataA = 8'h3C;
    bus.reqB = 1'b1; bus.wrB = 1'b0; bus.addrB = 3'd5;
    for (int c = 0; c < 12 && !(got_a && got_rd); c++) begin
      @(posedge clk); #1;
      if (drop_a) begin bus.reqA = 1'b0; drop_a = 0; end
      if (drop_b) begin bus.reqB = 1'b0; drop_b = 0; end
      if (bus.ackA) begin if (first == 0) first = 1; got_a = 1; drop_a = 1; end
      if (bus.ackB) begin if (first == 0) first = 2; drop_b = 1; end
      if (bus.rvalidB) begin got_rd = 1; rd = bus.rdata; end
    end
    @(posedge clk); #1;
    bus.reqA = 1'b0; bus.reqB = 1'b0;
    n_cmp++; if (!(got_a && got_rd)) begin
      n_err++; $display("FAIL mix_timeout: got ackA_seen=%b rvalidB_seen=%b want 1 1", got_a, got_rd); end
`ifdef RF_ARB_FIXED_PRIO_EN
    n_cmp++; if (first != 1) begin n_err++; $display("FAIL mix_first: got %0d want 1 (A)", first); end
`else
    n_cmp++; if (first != 2) begin n_err++; $display("FAIL mix_first: got %0d want 2 (B)", first); end
`endif
    n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL mix_rdata: got %h want %h", rd, exp_rd); end
    n_cmp++; if (rf[5] !== 8'h3C) begin n_err++; $display("FAIL mix_rf5: got %h want 3c", rf[5]); end
  endtask

  task automatic test_reset_midop();
    a_write(3'd4, 8'h44);
    bus.reqA = 1'b1; bus.wrA = 1'b1; bus.addrA = 3'd4; bus.wdataA = 8'h77;
    @(posedge clk); #1;
    n_cmp++; if (bus.WEN !== 1'b1) begin n_err++; $display("FAIL mid_issue: got WEN=%b want 1", bus.WEN); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (bus.WEN !== 1'b0 || bus.ackA !== 1'b0) begin
      n_err++; $display("FAIL mid_abort: got WEN=%b ackA=%b want 0 0", bus.WEN, bus.ackA); end
    bus.reqA = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rf[4] !== 8'h44) begin n_err++; $display("FAIL mid_rf4: got %h want 44", rf[4]); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({bus.WEN, bus.ackA, bus.ackB, bus.rdata} !== 11'h0) begin
      n_err++; $display("FAIL mid_after: got WEN=%b ackA=%b ackB=%b rdata=%h want 0 0 0 00",
                        bus.WEN, bus.ackA, bus.ackB, bus.rdata); end
  endtask

  initial begin
    bus.reqA = 1'b0; bus.wrA = 1'b0; bus.addrA = '0; bus.wdataA = '0;
    bus.reqB = 1'b0; bus.wrB = 1'b0; bus.addrB = '0; bus.wdataB = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_reg0();
    test_mixed();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 want finish earlier");
    $fatal(1, "watchdog expired");
  end
endmodule
